// File: rtl/param_selfstart_counter_if.sv
// Control/status bundle for param_selfstart_counter.
// count_gray is present only when COUNTER_GRAY_EN is defined.
interface param_selfstart_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             err_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             err;
`ifdef COUNTER_GRAY_EN
  logic [WIDTH-1:0] count_gray;

  modport master (
    output en, up_dn, load, load_val, err_clr,
    input  count, tc, wrap, err, count_gray
  );
  modport slave (
    input  en, up_dn, load, load_val, err_clr,
    output count, tc, wrap, err, count_gray
  );
`else
  modport master (
    output en, up_dn, load, load_val, err_clr,
    input  count, tc, wrap, err
  );
  modport slave (
    input  en, up_dn, load, load_val, err_clr,
    output count, tc, wrap, err
  );
`endif
endinterface

// File: rtl/param_selfstart_counter.sv
// Self-starting modulo-(MAX_COUNT+1) up/down counter with load, sticky error and cascade tc.
// Optional registered Gray output enabled by defining COUNTER_GRAY_EN.
module param_selfstart_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 11
) (
  input logic                    clk,
  input logic                    reset,
  param_selfstart_counter_if.slave bus
);

  generate
    if (WIDTH < 1 || WIDTH > 16 || MAX_COUNT < 1 || MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_param
      $fatal(1, "param_selfstart_counter: illegal WIDTH=%0d / MAX_COUNT=%0d", WIDTH, MAX_COUNT);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] count_p0;
  logic             wrap_p0;
  logic             err_p0;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             err_set;

  // Priority: illegal recovery > load > step > hold; reset handled in the register
  always_comb begin
    count_nxt = count_p0;
    wrap_nxt  = 1'b0;
    err_set   = 1'b0;
    if (count_p0 > MAX_C) begin
      count_nxt = '0;
      err_set   = 1'b1;
    end else if (bus.load) begin
      if (bus.load_val > MAX_C) begin
        count_nxt = '0;
        err_set   = 1'b1;
      end else begin
        count_nxt = bus.load_val;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (count_p0 == MAX_C) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count_p0 + 1'b1;
        end
      end else begin
        if (count_p0 == '0) begin
          count_nxt = MAX_C;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count_p0 - 1'b1;
        end
      end
    end
  end

  // Stage p0: state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_p0 <= '0;
      wrap_p0  <= 1'b0;
      err_p0   <= 1'b0;
    end else begin
      count_p0 <= count_nxt;
      wrap_p0  <= wrap_nxt;
      if (err_set)
        err_p0 <= 1'b1;
      else if (bus.err_clr)
        err_p0 <= 1'b0;
    end
  end

`ifdef COUNTER_GRAY_EN
  logic [WIDTH-1:0] count_gray_p0;

  // Gray copy tracks the next binary value so it stays aligned with count
  always_ff @(posedge clk) begin
    if (reset)
      count_gray_p0 <= '0;
    else
      count_gray_p0 <= bin2gray(count_nxt);
  end

  assign bus.count_gray = count_gray_p0;
`endif

  assign bus.count = count_p0;
  assign bus.wrap  = wrap_p0;
  assign bus.err   = err_p0;
  assign bus.tc    = bus.en & ((bus.up_dn & (count_p0 == MAX_C)) |
                               (~bus.up_dn & (count_p0 == '0)));

endmodule

// File: tb/tb_param_selfstart_counter.sv
// Directed bench for param_selfstart_counter: default 4-bit/mod-12 instance plus a 3-bit full-range one.
module tb_param_selfstart_counter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  param_selfstart_counter_if #(.WIDTH(4)) bus ();
  param_selfstart_counter_if #(.WIDTH(3)) bus3 ();

  param_selfstart_counter #(.WIDTH(4), .MAX_COUNT(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  param_selfstart_counter #(.WIDTH(3), .MAX_COUNT(7)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [3:0] c, input logic w, input logic e);
    chk({tag, ".count"}, 16'(bus.count), 16'(c));
    chk({tag, ".wrap"},  16'(bus.wrap),  16'(w));
    chk({tag, ".err"},   16'(bus.err),   16'(e));
`ifdef COUNTER_GRAY_EN
    chk({tag, ".gray"},  16'(bus.count_gray), 16'(c ^ (c >> 1)));
`endif
  endtask

  logic [3:0] exp_c;
  logic [2:0] exp_c3;
  logic [3:0] codes [3];

  initial begin
    errors   = 0;
    checks   = 0;
    codes[0] = 4'd14;
    codes[1] = 4'd12;
    codes[2] = 4'd15;
    reset = 1'b1;
    bus.en = 1'b0; bus.up_dn = 1'b1; bus.load = 1'b0; bus.load_val = '0; bus.err_clr = 1'b0;
    bus3.en = 1'b0; bus3.up_dn = 1'b1; bus3.load = 1'b0; bus3.load_val = '0; bus3.err_clr = 1'b0;
    tick();
    tick();
    chk_main("reset", 4'd0, 1'b0, 1'b0);
    chk("reset.tc", 16'(bus.tc), 16'd0);
    chk("reset3.count", 16'(bus3.count), 16'd0);

    // Scenario 1: up count with wrap on both instances
    reset = 1'b0;
    bus.en = 1'b1; bus.up_dn = 1'b1;
    bus3.en = 1'b1; bus3.up_dn = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      exp_c = 4'(i % 12);
      chk_main("up", exp_c, (i == 12), 1'b0);
      chk("up.tc", 16'(bus.tc), 16'(exp_c == 4'd11));
      exp_c3 = 3'(i % 8);
      chk("up3.count", 16'(bus3.count), 16'(exp_c3));
      chk("up3.wrap",  16'(bus3.wrap),  16'(i == 8));
      chk("up3.tc",    16'(bus3.tc),    16'(exp_c3 == 3'd7));
`ifdef COUNTER_GRAY_EN
      chk("up3.gray",  16'(bus3.count_gray), 16'(exp_c3 ^ (exp_c3 >> 1)));
`endif
    end
    bus3.en = 1'b0;

    // Scenario 2: load 0 then count down through the wrap
    bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd0;
    tick();
    chk_main("load0", 4'd0, 1'b0, 1'b0);
    bus.load = 1'b0; bus.en = 1'b1; bus.up_dn = 1'b0;
    #1;
    chk("dn.tc_at0", 16'(bus.tc), 16'd1);
    tick();
    chk_main("dn1", 4'd11, 1'b1, 1'b0);
    chk("dn1.tc", 16'(bus.tc), 16'd0);
    tick();
    chk_main("dn2", 4'd10, 1'b0, 1'b0);

    // Scenario 3: illegal load, clear, set-wins-over-clear
    bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd13;
    tick();
    chk_main("badload", 4'd0, 1'b0, 1'b1);
    bus.load = 1'b0; bus.err_clr = 1'b1;
    tick();
    chk_main("errclr", 4'd0, 1'b0, 1'b0);
    bus.load = 1'b1; bus.load_val = 4'd14; bus.err_clr = 1'b1;
    tick();
    chk_main("setwins", 4'd0, 1'b0, 1'b1);
    bus.err_clr = 1'b0; bus.load_val = 4'd9;
    tick();
    chk_main("load9", 4'd9, 1'b0, 1'b1);
    bus.load = 1'b0; bus.err_clr = 1'b1;
    tick();
    chk_main("clr9", 4'd9, 1'b0, 1'b0);
    bus.err_clr = 1'b0;

    // Scenario 4: forced illegal codes recover in one clock, ignoring a load
    for (int k = 0; k < 3; k++) begin
      bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd5;
      force dut.count_p0 = codes[k];
      #1;
      release dut.count_p0;
      #1;
      chk("force.count", 16'(bus.count), 16'(codes[k]));
      tick();
      chk_main("recover", 4'd0, 1'b0, 1'b1);
      if (k < 2) begin
        bus.load = 1'b0; bus.err_clr = 1'b1;
        tick();
        chk_main("recclr", 4'd0, 1'b0, 1'b0);
        bus.err_clr = 1'b0;
      end
    end

    // Scenario 5: reset overrides load/en and clears a set err
    bus.load = 1'b1; bus.load_val = 4'd7; bus.en = 1'b0;
    tick();
    chk_main("load7", 4'd7, 1'b0, 1'b1);
    bus.en = 1'b1; bus.up_dn = 1'b1; bus.load_val = 4'd3; reset = 1'b1;
    tick();
    chk_main("midreset", 4'd0, 1'b0, 1'b0);
    reset = 1'b0; bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'd6;
    tick();
    chk_main("load6", 4'd6, 1'b0, 1'b0);
    bus.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_main("hold", 4'd6, 1'b0, 1'b0);
    end

    // tc gating by en and direction at MAX_COUNT
    bus.load = 1'b1; bus.load_val = 4'd11;
    tick();
    bus.load = 1'b0;
    #1;
    chk("tc.en0", 16'(bus.tc), 16'd0);
    bus.en = 1'b1; bus.up_dn = 1'b1;
    #1;
    chk("tc.up", 16'(bus.tc), 16'd1);
    bus.up_dn = 1'b0;
    #1;
    chk("tc.dn", 16'(bus.tc), 16'd0);
    tick();
    chk_main("dn_from11", 4'd10, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
